// File: rtl/fc_out_layer_pkg.sv
// rtl/fc_out_layer_pkg.sv - shared widths, FSM encodings and score saturation for the output FC layer
package fc_out_layer_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC    = 8;
  localparam int ACC_W   = 40;
  localparam int N_CLASS = 10;

  // Controller states; BADD is the cycle in which the bias word returned by the ROM is added
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACCUM = 3'd1;
  localparam logic [2:0] ST_BIAS  = 3'd2;
  localparam logic [2:0] ST_BADD  = 3'd3;
  localparam logic [2:0] ST_SAT   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Score limits expressed at accumulator width so the clamp compares like with like
  localparam logic signed [ACC_W-1:0] SCORE_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SCORE_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Drop the extra fraction bits, clamp to 16 bits, optionally flip the MSB so that
  // the downstream unsigned argmax orders scores the same way as signed values
  function automatic logic [DATA_W-1:0] sat_score(input logic signed [ACC_W-1:0] acc,
                                                  input logic                    offset_bin);
    logic signed [ACC_W-1:0] s;
    logic [DATA_W-1:0]       r;
    s = acc >>> FRAC;
    if (s > SCORE_MAX) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (s < SCORE_MIN) begin
      r = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r = s[DATA_W-1:0];
    end
    if (offset_bin) begin
      r[DATA_W-1] = ~r[DATA_W-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_out_layer_mac_lane.sv
// rtl/fc_out_layer_mac_lane.sv - one class lane: signed multiply-accumulate, bias add and saturated score
module fc_out_layer_mac_lane
  import fc_out_layer_pkg::*;
#(
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en_mac,
  input  logic                     en_bias,
  input  logic signed [DATA_W-1:0] feat,
  input  logic signed [DATA_W-1:0] wt,
  output logic        [DATA_W-1:0] score
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;

  // Full-precision product and bias, both aligned to the accumulator's 2*FRAC fraction
  always_comb begin
    prod     = feat * wt;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_W-FRAC){wt[DATA_W-1]}}, wt, {FRAC{1'b0}}};
  end

  // Accumulator update: clear wins, then feature products, then the single bias add
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en_mac) begin
      acc_d = acc_q + prod_ext;
    end else if (en_bias) begin
      acc_d = acc_q + bias_ext;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign score = sat_score(acc_q, OFFSET_BIN);

endmodule

// File: rtl/fc_out_layer.sv
// rtl/fc_out_layer.sv - final LeNet FC layer: streams features, computes 10 biased scores, holds them for argmax
module fc_out_layer
  import fc_out_layer_pkg::*;
#(
  parameter int N_IN       = 84,
  parameter int ADDR_W     = 7,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        w_rd,
  output logic [ADDR_W-1:0]           w_addr,
  input  logic [N_CLASS*DATA_W-1:0]   w_data,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           class0,
  output logic [DATA_W-1:0]           class1,
  output logic [DATA_W-1:0]           class2,
  output logic [DATA_W-1:0]           class3,
  output logic [DATA_W-1:0]           class4,
  output logic [DATA_W-1:0]           class5,
  output logic [DATA_W-1:0]           class6,
  output logic [DATA_W-1:0]           class7,
  output logic [DATA_W-1:0]           class8,
  output logic [DATA_W-1:0]           class9,
  output logic                        err_len
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] feat_q, feat_d;
  logic              mac_en_q, mac_en_d;
  logic              in_ready_q, in_ready_d;
  logic              err_len_q, err_len_d;
  logic [DATA_W-1:0] class_q [N_CLASS];
  logic [DATA_W-1:0] class_d [N_CLASS];
  logic [DATA_W-1:0] lane_score [N_CLASS];

  logic accept;
  logic last_cnt;

  assign accept   = in_valid && in_ready_q;
  assign last_cnt = (cnt_q == ADDR_W'(N_IN - 1));

  // Controller: count beats, close the vector on in_last or the N_IN-th beat, then sequence bias/sat/done
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_len_d = err_len_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (in_last || last_cnt) begin
            state_d = ST_BIAS;
            if (!(in_last && last_cnt)) begin
              err_len_d = 1'b1;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_BIAS: state_d = ST_BADD;
      ST_BADD: state_d = ST_SAT;
      ST_SAT:  state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
  end

  // Datapath staging: delay the feature one cycle to meet the ROM word, capture scores in SAT
  always_comb begin
    feat_d   = accept ? in_data : feat_q;
    mac_en_d = accept;
    for (int k = 0; k < N_CLASS; k++) begin
      class_d[k] = (state_q == ST_SAT) ? lane_score[k] : class_q[k];
    end
  end

  // State, counter, staging and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      feat_q     <= '0;
      mac_en_q   <= 1'b0;
      in_ready_q <= 1'b0;
      err_len_q  <= 1'b0;
      for (int k = 0; k < N_CLASS; k++) begin
        class_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      feat_q     <= feat_d;
      mac_en_q   <= mac_en_d;
      in_ready_q <= in_ready_d;
      err_len_q  <= err_len_d;
      for (int k = 0; k < N_CLASS; k++) begin
        class_q[k] <= class_d[k];
      end
    end
  end

  for (genvar k = 0; k < N_CLASS; k++) begin : g_lane
    fc_out_layer_mac_lane #(
      .OFFSET_BIN(OFFSET_BIN)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q == ST_DONE),
      .en_mac (mac_en_q),
      .en_bias(state_q == ST_BADD),
      .feat   (feat_q),
      .wt     (w_data[k*DATA_W +: DATA_W]),
      .score  (lane_score[k])
    );
  end

  assign in_ready  = in_ready_q;
  assign w_rd      = accept || (state_q == ST_BIAS);
  assign w_addr    = (state_q == ST_BIAS) ? ADDR_W'(N_IN) : cnt_q;
  assign out_valid = (state_q == ST_DONE);
  assign err_len   = err_len_q;
  assign class0    = class_q[0];
  assign class1    = class_q[1];
  assign class2    = class_q[2];
  assign class3    = class_q[3];
  assign class4    = class_q[4];
  assign class5    = class_q[5];
  assign class6    = class_q[6];
  assign class7    = class_q[7];
  assign class8    = class_q[8];
  assign class9    = class_q[9];

endmodule
